// File: rtl/decoder_7segment_main.sv
// -----------------------------------------------------------------------------
// decoder_7segment_main
//
// Registered hex-to-7-segment decoder. Decodes a 4-bit nibble A (0..F) into the
// segment drive for one seven-segment digit (0-9, A b C d E F). The output is
// taken straight from a 7-bit register, so the display pins cannot glitch.
//
// Parameters
//   ACTIVE_LOW  0 = active-high segment drive (common cathode)
//               1 = inverted segment drive (common anode)
//
// Ports
//   clk    in   1  clock, rising edge
//   rst    in   1  asynchronous, active-high reset (all segments off)
//   en     in   1  load enable; Y only updates when en=1
//   lt     in   1  lamp test (only with DECODER7SEG_LAMP_TEST_EN defined)
//   blank  in   1  forces all segments off, beats the decode
//   A      in   4  hex digit to display
//   Y      out  7  segment drive {a,b,c,d,e,f,g}; Y[6]=a ... Y[0]=g
//
// Build option
//   DECODER7SEG_LAMP_TEST_EN  when defined, adds port lt. lt=1 with en=1 loads
//   all segments on. Priority at the sampled edge: rst > lt > blank > decode.
//   When undefined there is no lt port and no lamp-test logic.
// -----------------------------------------------------------------------------
module decoder_7segment_main #(
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
`ifdef DECODER7SEG_LAMP_TEST_EN
   input  logic       lt,
`endif
   input  logic       blank,
   input  logic [3:0] A,
   output logic [6:0] Y
);

   // Segment patterns are built active-high and inverted once at the end.
   localparam logic [6:0] SEG_ALL_OFF = 7'h00;
   localparam logic [6:0] SEG_ALL_ON  = 7'h7F;
   localparam logic [6:0] PIN_OFF     = ACTIVE_LOW ? ~SEG_ALL_OFF : SEG_ALL_OFF;

   logic [6:0] y_q;
   logic [6:0] y_d;
   logic [6:0] seg_hi;     // decoded pattern, active-high
   logic [6:0] load_hi;    // pattern chosen for loading, active-high

   // Full 16-entry table: every nibble is a displayable hex digit.
   always_comb begin
      seg_hi = SEG_ALL_OFF;
      unique case (A)
         4'h0: seg_hi = 7'h7E;
         4'h1: seg_hi = 7'h30;
         4'h2: seg_hi = 7'h6D;
         4'h3: seg_hi = 7'h79;
         4'h4: seg_hi = 7'h33;
         4'h5: seg_hi = 7'h5B;
         4'h6: seg_hi = 7'h5F;
         4'h7: seg_hi = 7'h70;
         4'h8: seg_hi = 7'h7F;
         4'h9: seg_hi = 7'h7B;
         4'hA: seg_hi = 7'h77;
         4'hB: seg_hi = 7'h1F;
         4'hC: seg_hi = 7'h4E;
         4'hD: seg_hi = 7'h3D;
         4'hE: seg_hi = 7'h4F;
         4'hF: seg_hi = 7'h47;
      endcase
   end

   always_comb begin
      load_hi = seg_hi;
`ifdef DECODER7SEG_LAMP_TEST_EN
      if (lt) begin
         load_hi = SEG_ALL_ON;
      end else if (blank) begin
         load_hi = SEG_ALL_OFF;
      end
`else
      if (blank) begin
         load_hi = SEG_ALL_OFF;
      end
`endif
   end

   // Hold when en=0; A, blank (and lt) are ignored then.
   always_comb begin
      y_d = y_q;
      if (en) begin
         y_d = ACTIVE_LOW ? ~load_hi : load_hi;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y_q <= PIN_OFF;
      end else begin
         y_q <= y_d;
      end
   end

   assign Y = y_q;

endmodule

// File: tb/tb_decoder_7segment_main.sv
// -----------------------------------------------------------------------------
// tb_decoder_7segment_main
//
// Directed bench for decoder_7segment_main. Two instances share the stimulus:
// one active-high (default), one with ACTIVE_LOW=1. Inputs change 1 time unit
// after a rising edge and outputs are sampled at the same point, away from
// the active edge. Define DECODER7SEG_LAMP_TEST_EN to include the lamp-test
// vectors.
// -----------------------------------------------------------------------------
module tb_decoder_7segment_main;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b0;
   logic       blank = 1'b0;
   logic [3:0] a_in = 4'h0;
   logic [6:0] y_hi;
   logic [6:0] y_lo;
`ifdef DECODER7SEG_LAMP_TEST_EN
   logic       lt = 1'b0;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   // Hand-copied active-high pattern table, index = nibble.
   logic [6:0] exp_tbl [16] = '{
      7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
      7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
   };

   always #5 clk = ~clk;

   decoder_7segment_main #(.ACTIVE_LOW(1'b0)) u_dut_hi (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
`ifdef DECODER7SEG_LAMP_TEST_EN
      .lt    (lt),
`endif
      .blank (blank),
      .A     (a_in),
      .Y     (y_hi)
   );

   decoder_7segment_main #(.ACTIVE_LOW(1'b1)) u_dut_lo (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
`ifdef DECODER7SEG_LAMP_TEST_EN
      .lt    (lt),
`endif
      .blank (blank),
      .A     (a_in),
      .Y     (y_lo)
   );

   task automatic check_eq(input string tag, input logic [6:0] got, input logic [6:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %02h expected %02h", tag, got, exp);
      end
   endtask

   // Advance to just past the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Asynchronous reset with no clock edge yet (first posedge at t=5).
      #1 rst = 1'b1;
      #1;
      check_eq("rst_async_hi", y_hi, 7'h00);
      check_eq("rst_async_lo", y_lo, 7'h7F);
      tick();
      rst = 1'b0;
      en  = 1'b1;

      // Sweep every nibble, one per cycle.
      for (int i = 0; i < 16; i++) begin
         a_in = 4'(i);
         tick();
         check_eq($sformatf("sweep_hi_%0h", i), y_hi, exp_tbl[i]);
         check_eq($sformatf("sweep_lo_%0h", i), y_lo, ~exp_tbl[i]);
      end

      // Spot values computed by hand for the inverted drive.
      a_in = 4'h0;
      tick();
      check_eq("lo_a0", y_lo, 7'h01);
      a_in = 4'h1;
      tick();
      check_eq("lo_a1", y_lo, 7'h4F);

      // Mid-stream reset from all-on: Y goes off before the next edge.
      a_in = 4'h8;
      tick();
      check_eq("pre_rst_hi", y_hi, 7'h7F);
      #2 rst = 1'b1;
      #1;
      check_eq("rst_mid_hi", y_hi, 7'h00);
      check_eq("rst_mid_lo", y_lo, 7'h7F);
      tick();
      check_eq("rst_hold_hi", y_hi, 7'h00);
      rst  = 1'b0;
      a_in = 4'h3;
      tick();
      check_eq("post_rst_hi", y_hi, 7'h79);

      // Hold while en=0.
      a_in = 4'h5;
      tick();
      check_eq("load5_hi", y_hi, 7'h5B);
      en   = 1'b0;
      a_in = 4'h2;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq($sformatf("hold_hi_%0d", i), y_hi, 7'h5B);
      end
      blank = 1'b1;
      tick();
      check_eq("hold_blank_ignored", y_hi, 7'h5B);
      blank = 1'b0;
      en    = 1'b1;
      tick();
      check_eq("reload2_hi", y_hi, 7'h6D);

      // Blank beats decode.
      blank = 1'b1;
      a_in  = 4'h8;
      tick();
      check_eq("blank_hi", y_hi, 7'h00);
      check_eq("blank_lo", y_lo, 7'h7F);
      blank = 1'b0;
      tick();
      check_eq("unblank_hi", y_hi, 7'h7F);
      check_eq("unblank_lo", y_lo, 7'h00);

`ifdef DECODER7SEG_LAMP_TEST_EN
      // Lamp test beats blank.
      lt    = 1'b1;
      blank = 1'b1;
      a_in  = 4'h1;
      tick();
      check_eq("lt_hi", y_hi, 7'h7F);
      check_eq("lt_lo", y_lo, 7'h00);
      lt = 1'b0;
      tick();
      check_eq("lt_off_blank_hi", y_hi, 7'h00);
      check_eq("lt_off_blank_lo", y_lo, 7'h7F);
      blank = 1'b0;
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
